// File: rtl/alu_issue_if.sv
// Handshake bundle between the ALU issue stage and its surroundings: command
// input, the combinational ALU hookup, and the registered response slot.
interface alu_issue_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_opcode;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_operand_a;
    logic [WIDTH-1:0] alu_operand_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_carry;
    logic             alu_overflow;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_carry;
    logic             rsp_overflow;
    logic             rsp_illegal;
    logic [CNTW-1:0]  fifo_count;

    // Environment side: issues commands, hosts the ALU, consumes responses.
    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
               alu_result, alu_zero, alu_carry, alu_overflow,
        input  cmd_ready, alu_opcode, alu_operand_a, alu_operand_b,
               rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_overflow,
               rsp_illegal, fifo_count
    );

    // Issue stage side.
    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
               alu_result, alu_zero, alu_carry, alu_overflow,
        output cmd_ready, alu_opcode, alu_operand_a, alu_operand_b,
               rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_overflow,
               rsp_illegal, fifo_count
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Command FIFO and registered response slot in front of the 8-bit combinational
// ALU. Opcodes the ALU does not implement are answered with rsp_illegal set.
module alu_issue_stage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input logic        clock,
    input logic        reset_n,
    alu_issue_if.slave bus
);
    localparam int         PTRW    = $clog2(DEPTH);
    localparam logic [3:0] OP_LAST = 4'b0101;

    logic [3:0]       op_mem_r [DEPTH];
    logic [WIDTH-1:0] a_mem_r  [DEPTH];
    logic [WIDTH-1:0] b_mem_r  [DEPTH];
    logic [PTRW-1:0]  wr_ptr_r;
    logic [PTRW-1:0]  rd_ptr_r;
    logic [CNTW-1:0]  count_r;

    logic             rsp_valid_r;
    logic [WIDTH-1:0] rsp_result_r;
    logic             rsp_zero_r;
    logic             rsp_carry_r;
    logic             rsp_overflow_r;
    logic             rsp_illegal_r;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic fire_s;
    logic illegal_s;

    assign full_s    = (count_r == CNTW'(DEPTH));
    assign empty_s   = (count_r == {CNTW{1'b0}});
    assign push_s    = bus.cmd_valid && !full_s;
    // A held response blocks issue unless it is being taken this very cycle.
    assign fire_s    = !empty_s && (!rsp_valid_r || bus.rsp_ready);
    assign illegal_s = (op_mem_r[rd_ptr_r] > OP_LAST);

    assign bus.cmd_ready    = !full_s;
    assign bus.fifo_count   = count_r;
    assign bus.rsp_valid    = rsp_valid_r;
    assign bus.rsp_result   = rsp_result_r;
    assign bus.rsp_zero     = rsp_zero_r;
    assign bus.rsp_carry    = rsp_carry_r;
    assign bus.rsp_overflow = rsp_overflow_r;
    assign bus.rsp_illegal  = rsp_illegal_r;

    // Present the FIFO head to the ALU, or all zeros when nothing is queued.
    always_comb begin
        bus.alu_opcode    = 4'h0;
        bus.alu_operand_a = {WIDTH{1'b0}};
        bus.alu_operand_b = {WIDTH{1'b0}};
        if (empty_s) begin
            bus.alu_opcode    = 4'h0;
            bus.alu_operand_a = {WIDTH{1'b0}};
            bus.alu_operand_b = {WIDTH{1'b0}};
        end else begin
            bus.alu_opcode    = op_mem_r[rd_ptr_r];
            bus.alu_operand_a = a_mem_r[rd_ptr_r];
            bus.alu_operand_b = b_mem_r[rd_ptr_r];
        end
    end

    // Command storage written at the tail on every accepted push.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_mem_r[i] <= 4'h0;
                a_mem_r[i]  <= {WIDTH{1'b0}};
                b_mem_r[i]  <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            op_mem_r[wr_ptr_r] <= bus.cmd_opcode;
            a_mem_r[wr_ptr_r]  <= bus.cmd_a;
            b_mem_r[wr_ptr_r]  <= bus.cmd_b;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTRW{1'b0}};
            rd_ptr_r <= {PTRW{1'b0}};
            count_r  <= {CNTW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTRW'(1);
            end
            if (fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTRW'(1);
            end
            case ({push_s, fire_s})
                2'b10:   count_r <= count_r + CNTW'(1);
                2'b01:   count_r <= count_r - CNTW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Response slot: capture on issue, clear valid on drain, otherwise hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_r    <= 1'b0;
            rsp_result_r   <= {WIDTH{1'b0}};
            rsp_zero_r     <= 1'b0;
            rsp_carry_r    <= 1'b0;
            rsp_overflow_r <= 1'b0;
            rsp_illegal_r  <= 1'b0;
        end else if (fire_s) begin
            rsp_valid_r <= 1'b1;
            if (illegal_s) begin
                rsp_result_r   <= {WIDTH{1'b0}};
                rsp_zero_r     <= 1'b0;
                rsp_carry_r    <= 1'b0;
                rsp_overflow_r <= 1'b0;
                rsp_illegal_r  <= 1'b1;
            end else begin
                rsp_result_r   <= bus.alu_result;
                rsp_zero_r     <= bus.alu_zero;
                rsp_carry_r    <= bus.alu_carry;
                rsp_overflow_r <= bus.alu_overflow;
                rsp_illegal_r  <= 1'b0;
            end
        end else if (rsp_valid_r && bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end
endmodule
